serial_frame_capture: RTL

- Receive end of the serial configuration/readout stream produced by the landscape-sampling clock system.
- Oversamples the slow serial clock (clk_data_de2), serial data and latch strobe on clk_main.
- Shifts one bit per serial-clock rising edge and commits a complete BIT_CHIP*NODE-bit frame on each latch rising edge.
- Flags frames whose bit count is wrong; used by the FPGA-side loopback/readback path and by the chip model in system benches.

---
 rtl/serial_frame_capture.sv | 97 +++++++++
 1 files changed

// File: rtl/serial_frame_capture.sv
// Receive-side capture of the landscape-sampling serial stream: oversamples sclk/sdata/latch
// on clk_main, shifts on sclk rising edges and commits a full frame on each latch rising edge.
module serial_frame_capture #(
  parameter int BIT_CHIP   = 6,
  parameter int NODE       = 16,
  parameter int FRAME_BITS = BIT_CHIP * NODE,
  parameter int CNT_W      = $clog2(FRAME_BITS + 2),
  parameter int FCNT_W     = 16
) (
  input  logic                  clk_main,
  input  logic                  clr_n,
  input  logic                  sclk,
  input  logic                  sdata,
  input  logic                  latch,
  output logic [FRAME_BITS-1:0] frame_data,
  output logic                  frame_valid,
  output logic                  frame_err,
  output logic [CNT_W-1:0]      bit_cnt,
  output logic [FCNT_W-1:0]     frame_cnt
);

  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0] CNT_OVF  = CNT_W'(FRAME_BITS + 1);

  logic                  sync1_sclk, sync2_sclk, hist_sclk;
  logic                  sync1_sdata, sync2_sdata;
  logic                  sync1_latch, sync2_latch, hist_latch;
  logic                  s_rise, l_rise;
  logic [FRAME_BITS-1:0] shreg, shreg_step;
  logic [CNT_W-1:0]      cnt_step;

  // sclk chain resets high so an idle-high serial clock never looks like a rise after reset.
  always_ff @(posedge clk_main) begin
    if (!clr_n) begin
      sync1_sclk  <= 1'b1;
      sync2_sclk  <= 1'b1;
      hist_sclk   <= 1'b1;
      sync1_sdata <= 1'b0;
      sync2_sdata <= 1'b0;
      sync1_latch <= 1'b0;
      sync2_latch <= 1'b0;
      hist_latch  <= 1'b0;
    end else begin
      sync1_sclk  <= sclk;
      sync2_sclk  <= sync1_sclk;
      hist_sclk   <= sync2_sclk;
      sync1_sdata <= sdata;
      sync2_sdata <= sync1_sdata;
      sync1_latch <= latch;
      sync2_latch <= sync1_latch;
      hist_latch  <= sync2_latch;
    end
  end

  // Shift result computed ahead of the commit so a coincident sclk rise counts toward this frame.
  always_comb begin
    s_rise     = sync2_sclk & ~hist_sclk;
    l_rise     = sync2_latch & ~hist_latch;
    shreg_step = shreg;
    cnt_step   = bit_cnt;
    if (s_rise) begin
      shreg_step = {shreg[FRAME_BITS-2:0], sync2_sdata};
      if (bit_cnt != CNT_OVF)
        cnt_step = bit_cnt + CNT_W'(1);
    end
  end

  // bit_cnt doubles as the state: 0 idle, 1..FRAME_BITS shifting, FRAME_BITS+1 overflow.
  always_ff @(posedge clk_main) begin
    if (!clr_n) begin
      shreg       <= '0;
      bit_cnt     <= '0;
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      if (l_rise) begin
        shreg   <= '0;
        bit_cnt <= '0;
        if (cnt_step == CNT_FULL) begin
          frame_data  <= shreg_step;
          frame_valid <= 1'b1;
          frame_cnt   <= frame_cnt + FCNT_W'(1);
        end else begin
          frame_err <= 1'b1;
        end
      end else begin
        shreg   <= shreg_step;
        bit_cnt <= cnt_step;
      end
    end
  end

endmodule
